// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_AW      : register-address width
//   FWD_*       : EX operand forwarding select encodings
//   sb_entry_t  : scoreboard entry for the instruction in EX
//   res_entry_t : result-producer view of the MEM stage
//   fwd_sel     : forwarding select for one EX source register
package pipe_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  // valid means "writes a non-zero register", i.e. can cause a hazard
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              is_load;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } sb_entry_t;

  // Once an instruction leaves EX its sources no longer matter
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              is_load;
  } res_entry_t;

  localparam sb_entry_t  SB_EMPTY  = '0;
  localparam res_entry_t RES_EMPTY = '0;

  // MEM wins over WB because it holds the newer value; a load in MEM
  // has no data yet, so it falls through to the WB check.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input res_entry_t        mem_e,
    input logic              wb_valid,
    input logic [REG_AW-1:0] wb_dst
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (mem_e.valid && !mem_e.is_load && (mem_e.dst == src)) begin
      sel = FWD_MEM;
    end else if (wb_valid && (wb_dst == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count this cycle (ignored while hold is set)
//   hold     : freeze the counter
//   count    : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!hold && inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Tracks in-flight instructions in EX/MEM/WB and, from them and the ID
// decode fields, drives pipeline enables/flushes, EX forwarding selects
// and stall/flush performance counters.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_*                     : decoded fields of the instruction in ID
//   ex_redirect              : taken branch / JR resolved in EX
//   mem_ready                : data memory ready, low freezes the pipe
//   pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en
//                            : pipeline register controls (combinational)
//   fwd_a, fwd_b             : EX operand forwarding selects (combinational)
//   stall_cnt, flush_cnt     : saturating event counters
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_jump,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t         ex_q;
  res_entry_t        mem_q;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_dst_q;

  sb_entry_t         id_entry;
  logic              freeze;
  logic              load_use;
  logic              issue;

  assign freeze = ~mem_ready;

  // Scoreboard entry the ID instruction would become; $0 never hazards
  always_comb begin
    id_entry         = SB_EMPTY;
    id_entry.valid   = id_regwrite & (id_dst != '0);
    id_entry.dst     = id_dst;
    id_entry.is_load = id_memread;
    id_entry.rs      = id_rs;
    id_entry.rt      = id_rt;
  end

  // Consumer in ID needs the result of a load still in EX
  always_comb begin
    load_use = ex_q.valid & ex_q.is_load &
               ((id_use_rs & (id_rs == ex_q.dst)) |
                (id_use_rt & (id_rt == ex_q.dst)));
    issue    = id_valid & ~load_use & ~ex_redirect;
  end

  // Scoreboard shift; a stalled or squashed ID slot enters EX as a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= SB_EMPTY;
      mem_q      <= RES_EMPTY;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
    end else if (!freeze) begin
      wb_valid_q    <= mem_q.valid;
      wb_dst_q      <= mem_q.dst;
      mem_q.valid   <= ex_q.valid;
      mem_q.dst     <= ex_q.dst;
      mem_q.is_load <= ex_q.is_load;
      ex_q          <= issue ? id_entry : SB_EMPTY;
    end
  end

  // Pipeline control, highest priority first
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    fwd_a      = fwd_sel(ex_q.rs, mem_q, wb_valid_q, wb_dst_q);
    fwd_b      = fwd_sel(ex_q.rt, mem_q, wb_valid_q, wb_dst_q);
    if (rst) begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end else if (freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // A redirect squashes the stalled consumer, so that stall is not counted
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_use & ~ex_redirect),
    .hold  (freeze),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ex_redirect | id_jump),
    .hold  (freeze),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Keeps its own 3-entry scoreboard of in-flight instructions (EX, MEM, WB). Each entry holds valid, dst, is_load, rs, rt.
- From the scoreboard and the control signals of the instruction in ID, it drives:
  - pipeline-register enables and flushes,
  - EX operand forwarding selects,
  - saturating stall/flush performance counters.
- Sits beside the decoder; consumes its RegWrite/RegDst/MemRead/J/JR-derived fields.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_rs  in  REG_AW  ID source register rs.
- id_rt  in  REG_AW  ID source register rt.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dst  in  REG_AW  ID destination (rd or rt, already muxed by RegDst).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- id_jump  in  1  J decoded in ID (resolved in ID).
- ex_redirect  in  1  taken branch or JR resolved in EX.
- mem_ready  in  1  data memory ready; 0 freezes the whole pipeline.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register becomes a bubble.
- idex_flush  out  1  ID/EX register becomes a bubble.
- exmem_en  out  1  EX/MEM register enable.
- memwb_en  out  1  MEM/WB register enable.
- fwd_a  out  2  EX operand-A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b  out  2  EX operand-B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  cycles lost to load-use stalls.
- flush_cnt  out  CNT_W  redirect and jump flush events.

Behaviour:
- Scoreboard:
  - An entry is valid only if its instruction writes the register file and dst != 0. Register $0 never creates a hazard.
  - Advance when not frozen: WB<=MEM, MEM<=EX, EX<=issue ? ID fields : invalid.
  - issue = id_valid & ~load_use & ~ex_redirect.
- load_use = EX.valid & EX.is_load & ((id_use_rs & id_rs==EX.dst) | (id_use_rt & id_rt==EX.dst)).
- Control priority (outputs combinational from inputs and registered scoreboard):
  1. freeze (mem_ready=0): all enables 0, both flushes 0, scoreboard and counters hold.
  2. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1. Overrides load_use; the stall is not counted.
  3. load_use: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble is inserted; the next cycle re-evaluates with the load in MEM.
  4. id_jump: ifid_flush=1, pc_en=1.
  5. default: all enables 1, all flushes 0.
- exmem_en and memwb_en are 0 only during freeze.
- Forwarding:
  - fwd_a checks EX.rs, fwd_b checks EX.rt.
  - 01 if MEM.valid & ~MEM.is_load & MEM.dst matches.
  - Otherwise 10 if WB.valid & WB.dst matches.
  - Otherwise 00. MEM has priority over WB.
  - A MEM load match cannot occur because load_use prevents it. In that case the select falls through to the WB/00 check.
- Counters:
  - stall_cnt increments on each non-frozen cycle with load_use & ~ex_redirect.
  - flush_cnt increments on each non-frozen cycle with ex_redirect or id_jump; a single +1 if both.
  - Both saturate at all-ones.
- Reset (asynchronous, any time including mid-stall or mid-freeze):
  - Scoreboard invalid and counters 0.
  - While rst is high, outputs are pc_en=ifid_en=exmem_en=memwb_en=1, flushes 0, fwd 00.
- Latency: hazard and forwarding decisions are same-cycle combinational. Scoreboard state takes effect one clock after issue.

Decomposition:
- Shared package pipe_pkg:
  - REG_AW,
  - forwarding encodings FWD_RF/FWD_MEM/FWD_WB,
  - scoreboard entry struct {valid, dst, is_load, rs, rt}.
- One natural sub-module: sat_counter (CNT_W, inc, hold, rst), instantiated twice.

Test Plan:
- `lw $2,0($1)` then `add $3,$2,$4` -> one cycle with pc_en=0/ifid_en=0/idex_flush=1; then `add` in EX with fwd_a=10; stall_cnt=1.
- `add $2,$1,$1` then `sub $5,$2,$2` -> no stall; fwd_a=01 and fwd_b=01 in `sub`'s EX cycle.
- `add $2..`, `add $2..`, `or $6,$2,$0` -> fwd_a=01, since the newer MEM result wins over WB.
- `add $0,$1,$1` then `add $3,$0,$0` -> fwd_a=fwd_b=00, no stall.
- Load-use stall coincident with ex_redirect=1 -> ifid_flush=idex_flush=1, pc_en=1; stall_cnt unchanged, flush_cnt+1.
- mem_ready=0 for 3 cycles mid-stream, then rst pulsed asynchronously mid-freeze -> all enables 0 during freeze with the scoreboard held; after rst: fwd 00, counters 0, enables 1.
